pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the 5-stage pipeline.
- Consumes the EX-stage next-instruction decision (redirect flag, target, EBREAK/ECALL qualifiers) and the hazard unit's stall.
- Drives the fetch PC, IF/ID and ID/EX flush strobes, and a halt/resume state machine for EBREAK.
- Captures the ECALL return PC and counts taken redirects for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0000, fetch target on ECALL.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request for the PC and IF/ID.
- ex_redirect  in  1  EX-stage jump/branch-taken flag (Jumpp).
- ex_target  in  32  EX-stage computed next PC (OutputtoPC).
- ex_pc  in  32  PC of the instruction currently in EX.
- ex_is_ebreak  in  1  EX instruction is EBREAK (qualified by ex_redirect).
- ex_is_ecall  in  1  EX instruction is ECALL (qualified by ex_redirect).
- resume  in  1  single-cycle pulse that leaves HALT.
- pc  out  32  current fetch address.
- pc_valid  out  1  fetch at pc is architecturally live.
- flush_ifid  out  1  kill the IF/ID contents this cycle.
- flush_idex  out  1  kill the ID/EX contents this cycle.
- halted  out  1  high while in HALT.
- epc  out  32  return PC latched on ECALL.
- misalign  out  1  sticky flag: a redirect target had ex_target[1:0] != 0.
- redirect_cnt  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (rst=1 at an edge) overrides everything, including mid-halt and mid-redirect:
  - pc=RESET_PC, pc_valid=1, state=RUN.
  - epc=0, misalign=0, redirect_cnt=0.
  - flush_ifid=flush_idex=0 while rst=1.
- States are RUN and HALT. `halted` = (state==HALT), registered.
- Flush outputs are combinational: asserted only in RUN, in the same cycle ex_redirect=1. Zero in HALT.
- RUN, per-edge priority (highest first):
  1. ex_redirect & ex_is_ebreak:
     - pc <= ex_pc; state <= HALT; pc_valid <= 0.
     - Flushes asserted; redirect_cnt increments.
  2. ex_redirect & ex_is_ecall:
     - pc <= TRAP_VEC; epc <= ex_pc + 4.
     - Flushes asserted; redirect_cnt increments.
  3. ex_redirect (plain JAL/JALR/branch):
     - pc <= {ex_target[31:2],2'b00}.
     - misalign <= misalign | (ex_target[1:0]!=0).
     - Flushes asserted; redirect_cnt increments.
  4. stall: pc holds.
  5. Otherwise: pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Redirect beats stall in the same cycle: the control transfer is never lost, and pc takes the target.
- ebreak and ecall both high: EBREAK wins.
- ex_is_ebreak or ex_is_ecall without ex_redirect: ignored, no state change.
- HALT:
  - pc held, pc_valid=0, flushes 0.
  - stall, ex_redirect and qualifiers are ignored.
  - resume=1: pc <= pc + 4, pc_valid <= 1, state <= RUN. RUN behaviour resumes on the next cycle.
  - resume in RUN: ignored.
- redirect_cnt saturates at all-ones. No wrap.
- Latency: a redirect sampled at edge N gives the new pc after edge N. The fetch in flight during cycle N is killed by the flush in cycle N.
- epc holds until the next ECALL or reset.

Test Plan:
- Reset release, no stall:
  - rst high for 2 cycles, then low → pc sequence 0,4,8,C on successive edges.
  - pc_valid=1, flushes 0, redirect_cnt=0.
- Redirect with concurrent stall:
  - At pc=0x10, drive stall=1, ex_redirect=1, ex_target=0x40 → flush_ifid=flush_idex=1 that cycle.
  - Next pc=0x40, redirect_cnt=1.
  - Then stall only for 2 cycles → pc holds 0x40.
- EBREAK halt/resume:
  - ex_redirect=1, ex_is_ebreak=1, ex_pc=0x24 → pc=0x24, halted=1, pc_valid=0.
  - Redirect pulses while halted → no change, flushes 0.
  - resume → pc=0x28, halted=0, pc_valid=1.
- ECALL trap, with TRAP_VEC=0x100:
  - ex_redirect=1, ex_is_ecall=1, ex_pc=0x30 → pc=0x100, epc=0x34.
  - ecall+ebreak together at ex_pc=0x50 → HALT at 0x50, epc unchanged.
- Misaligned target and wrap:
  - ex_target=0x43 → pc=0x40, misalign=1 and stays 1 after a later aligned redirect.
  - RESET_PC=0xFFFFFFFC → the next pc is 0x0.
- Reset mid-halt and counter saturation:
  - rst asserted in HALT → pc=RESET_PC, state RUN, epc=0.
  - With CNT_W=2, 5 redirects → redirect_cnt=3.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner for the 5-stage pipeline: fetch sequencing, EX redirects,
// ECALL trap entry, EBREAK halt/resume, plus sticky misalign flag and redirect counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_ebreak,
  input  logic             ex_is_ecall,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [31:0]      epc,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [31:0]      r_pc, w_pc_next;
  logic             r_pc_valid, w_pc_valid_next;
  logic [31:0]      r_epc, w_epc_next;
  logic             r_misalign, w_misalign_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run, w_take;

  assign w_run  = (r_state == ST_RUN);
  // Only redirects seen in RUN are architecturally accepted; HALT ignores EX.
  assign w_take = w_run & ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (ex_redirect && ex_is_ebreak) w_state_next = ST_HALT;
      ST_HALT: if (resume)                      w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    flush_ifid = w_take & ~rst;
    flush_idex = w_take & ~rst;
    halted     = (r_state == ST_HALT);
  end

  always_comb begin
    w_pc_next       = r_pc;
    w_pc_valid_next = r_pc_valid;
    w_epc_next      = r_epc;
    w_misalign_next = r_misalign;
    if (w_run) begin
      if (w_take && ex_is_ebreak) begin
        w_pc_next       = ex_pc;
        w_pc_valid_next = 1'b0;
      end else if (w_take && ex_is_ecall) begin
        w_pc_next  = TRAP_VEC;
        w_epc_next = ex_pc + 32'd4;
      end else if (w_take) begin
        w_pc_next       = {ex_target[31:2], 2'b00};
        w_misalign_next = r_misalign | (ex_target[1:0] != 2'b00);
      end else if (!stall) begin
        w_pc_next = r_pc + 32'd4;
      end
    end else if (resume) begin
      w_pc_next       = r_pc + 32'd4;
      w_pc_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b1;
      r_epc      <= 32'd0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_pc_valid <= w_pc_valid_next;
      r_epc      <= w_epc_next;
      r_misalign <= w_misalign_next;
      if (w_take && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign epc          = r_epc;
  assign misalign     = r_misalign;
  assign redirect_cnt = r_cnt;

endmodule
